// File: rtl/calc_unit_pkg.sv
// Shared width helpers, constants and the saturating adder for the calc unit.
// The saturating adder is used only when CALC_UNIT_MULTIBIT_SAT_EN is defined.
package calc_unit_pkg;

    localparam int MAX_A_BITS     = 4;
    localparam int SAT_CALC_WIDTH = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int term_width(input int w, input int a);
        return cnt_width(w) + a + 1;
    endfunction

    // Clamp a+b to the signed range of a w-bit word; operands arrive sign-extended.
    function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_add(
        input logic signed [SAT_CALC_WIDTH-1:0] a,
        input logic signed [SAT_CALC_WIDTH-1:0] b,
        input int                               w
    );
        logic signed [SAT_CALC_WIDTH:0] sum;
        logic signed [SAT_CALC_WIDTH:0] hi;
        logic signed [SAT_CALC_WIDTH:0] lo;
        sum = (SAT_CALC_WIDTH + 1)'(a) + (SAT_CALC_WIDTH + 1)'(b);
        hi  = ((SAT_CALC_WIDTH + 1)'(1) <<< (w - 1)) - (SAT_CALC_WIDTH + 1)'(1);
        lo  = -((SAT_CALC_WIDTH + 1)'(1) <<< (w - 1));
        if (sum > hi) begin
            return hi[SAT_CALC_WIDTH-1:0];
        end else if (sum < lo) begin
            return lo[SAT_CALC_WIDTH-1:0];
        end
        return sum[SAT_CALC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/popcount_param.sv
// Purely combinational population count of a WIDTH-bit word.
module popcount_param #(
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/calc_unit_multibit.sv
// Multi-bit activation x binary kernel XNOR-popcount dot product, accumulated over beats.
// Optional build macro CALC_UNIT_MULTIBIT_SAT_EN makes the accumulator add saturate.
module calc_unit_multibit
    import calc_unit_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int A_BITS     = 2,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [A_BITS*WORD_WIDTH-1:0] in_rdata,
    input  logic [WORD_WIDTH-1:0]        kn_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data
);

    localparam int CNT_WIDTH  = cnt_width(WORD_WIDTH);
    localparam int TERM_WIDTH = term_width(WORD_WIDTH, A_BITS);

    logic [A_BITS-1:0][CNT_WIDTH-1:0] pcPlane;
    logic [CNT_WIDTH-1:0]             pcNeg;

    // One popcount per bit-plane match count, plus one for the -1 kernel positions.
    for (genvar b = 0; b < A_BITS; b++) begin : gPlane
        popcount_param #(.WIDTH(WORD_WIDTH)) uPcPlane (
            .data_i  (~(in_rdata[b*WORD_WIDTH +: WORD_WIDTH] ^ kn_rdata)),
            .count_o (pcPlane[b])
        );
    end

    popcount_param #(.WIDTH(WORD_WIDTH)) uPcNeg (
        .data_i  (~kn_rdata),
        .count_o (pcNeg)
    );

    logic                             adv;
    logic [A_BITS-1:0][CNT_WIDTH-1:0] pcPlane_q, pcPlane_d;
    logic [CNT_WIDTH-1:0]             pcNeg_q, pcNeg_d;
    logic                             s1Valid_q, s1Valid_d;
    logic                             s1First_q, s1First_d;
    logic                             s1Last_q, s1Last_d;
    logic signed [TERM_WIDTH-1:0]     termCalc;
    logic signed [TERM_WIDTH-1:0]     term_q, term_d;
    logic                             s2Valid_q, s2Valid_d;
    logic                             s2First_q, s2First_d;
    logic                             s2Last_q, s2Last_d;
    logic signed [OUT_WIDTH-1:0]      termExt;
    logic signed [OUT_WIDTH-1:0]      accSum;
    logic signed [OUT_WIDTH-1:0]      acc_q, acc_d;
    logic                             s3Last_q, s3Last_d;
    logic                             outValid_q, outValid_d;
    logic [OUT_WIDTH-1:0]             outData_q, outData_d;

    assign adv       = ~(outValid_q & ~out_ready);
    assign in_ready  = adv;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;

    // Weight each plane match count by 2^b, then remove (2^A_BITS-1) per -1 kernel bit.
    always_comb begin
        termCalc = '0;
        for (int b = 0; b < A_BITS; b++) begin
            termCalc = termCalc + (TERM_WIDTH'(pcPlane_q[b]) << b);
        end
        termCalc = termCalc - ((TERM_WIDTH'(pcNeg_q) << A_BITS) - TERM_WIDTH'(pcNeg_q));
    end

    assign termExt = OUT_WIDTH'(term_q);

`ifdef CALC_UNIT_MULTIBIT_SAT_EN
    assign accSum = OUT_WIDTH'(sat_add(SAT_CALC_WIDTH'(acc_q), SAT_CALC_WIDTH'(termExt), OUT_WIDTH));
`else
    assign accSum = acc_q + termExt;
`endif

    // The result register sits one edge behind the accumulator, fed by the S3 last tag.
    always_comb begin
        pcPlane_d  = pcPlane_q;
        pcNeg_d    = pcNeg_q;
        s1Valid_d  = s1Valid_q;
        s1First_d  = s1First_q;
        s1Last_d   = s1Last_q;
        term_d     = term_q;
        s2Valid_d  = s2Valid_q;
        s2First_d  = s2First_q;
        s2Last_d   = s2Last_q;
        acc_d      = acc_q;
        s3Last_d   = s3Last_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        if (adv) begin
            pcPlane_d  = pcPlane;
            pcNeg_d    = pcNeg;
            s1Valid_d  = in_valid;
            s1First_d  = in_first;
            s1Last_d   = in_last;
            term_d     = termCalc;
            s2Valid_d  = s1Valid_q;
            s2First_d  = s1First_q;
            s2Last_d   = s1Last_q;
            s3Last_d   = s2Valid_q & s2Last_q;
            if (s2Valid_q) begin
                acc_d = s2First_q ? termExt : accSum;
            end
            outValid_d = s3Last_q;
            if (s3Last_q) begin
                outData_d = acc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcPlane_q  <= '0;
            pcNeg_q    <= '0;
            s1Valid_q  <= 1'b0;
            s1First_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            term_q     <= '0;
            s2Valid_q  <= 1'b0;
            s2First_q  <= 1'b0;
            s2Last_q   <= 1'b0;
            acc_q      <= '0;
            s3Last_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            pcPlane_q  <= pcPlane_d;
            pcNeg_q    <= pcNeg_d;
            s1Valid_q  <= s1Valid_d;
            s1First_q  <= s1First_d;
            s1Last_q   <= s1Last_d;
            term_q     <= term_d;
            s2Valid_q  <= s2Valid_d;
            s2First_q  <= s2First_d;
            s2Last_q   <= s2Last_d;
            acc_q      <= acc_d;
            s3Last_q   <= s3Last_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

endmodule
